// File: rtl/sync_fifo_pkg.sv
// Shared width helpers, parameter checks and read-mode encoding for the single-clock FIFO.
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Address bits needed to index DEPTH entries (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

    // Pointer and occupancy width: one extra bit so DEPTH itself is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return addr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic fifo_mode_e mode_of(input int unsigned fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// WIDTH x DEPTH storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       wr_en_i,
    input  logic [addr_w(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic [addr_w(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]           rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and selectable standard or first-word-fall-through read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int unsigned ADDR_W = addr_w(DEPTH);
    localparam int unsigned CNT_W  = cnt_w(DEPTH);
    localparam fifo_mode_e  MODE   = mode_of(FWFT);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must be below DEPTH");
    end

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             afull_q,  afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc & ~rst),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (mem_rdata)
    );

    // Acceptance uses the registered flags, so a read never frees room for a same-cycle write.
    always_comb begin
        wr_acc     = wr_en & ~full_q;
        rd_acc     = rd_en & ~empty_q;

        wr_ptr_d   = wr_ptr_q + CNT_W'(wr_acc);
        rd_ptr_d   = rd_ptr_q + CNT_W'(rd_acc);
        count_d    = wr_ptr_d - rd_ptr_d;

        full_d     = (count_d == DEPTH_C);
        empty_d    = (count_d == '0);
        afull_d    = (count_d >= AF_C);
        aempty_d   = (count_d <= AE_C);

        ovf_d      = (wr_en & full_q)  | (ovf_q & ~clr_err);
        udf_d      = (rd_en & empty_q) | (udf_q & ~clr_err);

        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // FWFT presents the head word straight from the array whenever the FIFO holds data.
    assign rd_data      = (MODE == FIFO_FWFT) ? mem_rdata : rd_data_q;
    assign rd_valid     = (MODE == FIFO_FWFT) ? ~empty_q  : rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench: standard and FWFT instances driven in lockstep, checked against a queue-based model.
module tb_sync_fifo_param;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = 5;

    logic         clk;
    logic         rst, wr_en, rd_en, clr_err;
    logic [W-1:0] wr_data;

    logic [W-1:0]  s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [CW-1:0] s_count, f_count;
    logic          s_ovf, f_ovf, s_udf, f_udf;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of stored words plus the sticky flags and std output.
    logic [W-1:0] mq[$];
    bit           m_ovf, m_udf, m_rv;
    logic [W-1:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit we, input logic [W-1:0] wd, input bit re,
                              input bit ce, input bit r);
        bit was_full, was_empty;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
        end else begin
            was_full  = (mq.size() == D);
            was_empty = (mq.size() == 0);
            m_rv = re && !was_empty;
            if (m_rv) m_rd = mq.pop_front();
            if (we && !was_full) mq.push_back(wd);
            m_ovf = (we && was_full)  || (m_ovf && !ce);
            m_udf = (re && was_empty) || (m_udf && !ce);
        end
    endtask

    task automatic step(input bit we, input logic [W-1:0] wd, input bit re,
                        input bit ce, input bit r);
        int n;
        rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
        @(posedge clk);
        model_edge(we, wd, re, ce, r);
        #1;
        n = mq.size();
        check("s_count",    32'(s_count),    32'(n));
        check("s_full",     32'(s_full),     32'(n == D));
        check("s_empty",    32'(s_empty),    32'(n == 0));
        check("s_afull",    32'(s_af),       32'(n >= D - 2));
        check("s_aempty",   32'(s_ae),       32'(n <= 2));
        check("s_overflow", 32'(s_ovf),      32'(m_ovf));
        check("s_underflow",32'(s_udf),      32'(m_udf));
        check("s_rd_valid", 32'(s_rd_valid), 32'(m_rv));
        check("s_rd_data",  32'(s_rd_data),  32'(m_rd));
        check("f_count",    32'(f_count),    32'(n));
        check("f_full",     32'(f_full),     32'(n == D));
        check("f_empty",    32'(f_empty),    32'(n == 0));
        check("f_afull",    32'(f_af),       32'(n >= D - 2));
        check("f_aempty",   32'(f_ae),       32'(n <= 2));
        check("f_overflow", 32'(f_ovf),      32'(m_ovf));
        check("f_underflow",32'(f_udf),      32'(m_udf));
        check("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) check("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
    endtask

    task automatic wr(input logic [W-1:0] d); step(1, d, 0, 0, 0); endtask
    task automatic rd();                      step(0, '0, 1, 0, 0); endtask
    task automatic idle();                    step(0, '0, 0, 0, 0); endtask

    initial begin
        int pw, pr;
        logic [W-1:0] rnd;
        rst = 1; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
        m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;

        step(0, '0, 0, 0, 1);
        idle();

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) wr(W'(i));
        wr(8'hAA);
        idle();

        // Drain in order, then one read too many.
        for (int i = 0; i < 16; i++) rd();
        rd();
        idle();
        step(0, '0, 0, 1, 0);

        // Steady state at 8 entries across pointer wrap.
        for (int i = 0; i < 8; i++) wr(W'($urandom));
        for (int i = 0; i < 100; i++) begin
            rnd = W'($urandom);
            step(1, rnd, 1, 0, 0);
        end

        // Simultaneous read/write at the full and empty boundaries.
        while (mq.size() < D) wr(W'($urandom));
        step(1, 8'h33, 1, 0, 0);
        while (mq.size() > 0) rd();
        step(1, 8'h5A, 1, 0, 0);
        idle();
        rd();
        idle();

        // Mid-stream reset with 9 entries and both error flags set.
        step(0, '0, 1, 0, 0);
        for (int i = 0; i < 9; i++) wr(W'($urandom));
        step(1, 8'h77, 0, 0, 1);
        wr(8'hC3);
        rd();
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);

        // Randomised traffic with shifting write/read bias.
        for (int blk = 0; blk < 6; blk++) begin
            pw = int'($urandom_range(20, 90));
            pr = int'($urandom_range(20, 90));
            for (int i = 0; i < 500; i++) begin
                rnd = W'($urandom);
                step(int'($urandom_range(0, 99)) < pw, rnd,
                     int'($urandom_range(0, 99)) < pr,
                     $urandom_range(0, 31) == 0,
                     $urandom_range(0, 299) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
